riscv_dmem_responder: RTL
=========================

Name: riscv_dmem_responder

Overview:
- Data-memory responder on the M-stage data port of the pipelined RV32I core.
- Accepts the core's address, store data, write strobe and funct3.
  - Returns load data combinationally in the same cycle.
  - Commits stores on the clock edge.
- Contains a word-organised RAM with byte-lane stores and load sign/zero extension.
- Also contains a small MMIO register window: GPIO output, free-running cycle counter, sticky error status.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words; must be a power of 2.
- MMIO_BASE, 32'h0000_1000, base of the 4 KB MMIO window; only bits [31:12] are compared.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- MemWriteM  input  1  store strobe from the M stage.
- ALUResultM  input  32  byte address.
- WriteDataM  input  32  store data, right-aligned.
- Func3M  input  3  access width/sign (RV32I load/store funct3).
- ReadDataM  output  32  load data, extended, combinational.
- GpioOut  output  32  GPIO_OUT register.
- ErrFlag  output  1  OR of ERR_STATUS bits.

Behaviour:
- Decode:
  - mmio = (ALUResultM[31:12] == MMIO_BASE[31:12]).
  - ram = !mmio && (ALUResultM >> 2) < DEPTH_WORDS.
  - Otherwise the address is out of range (oor).
- RAM word index is ALUResultM[log2(DEPTH_WORDS)+1:2]. RAM contents are not reset.
- Loads are combinational; there is no read strobe, so ReadDataM always reflects the current address:
  - 000 LB: byte at addr[1:0], sign-extended.
  - 100 LBU: byte at addr[1:0], zero-extended.
  - 001 LH: half at addr[1], sign-extended; addr[0] ignored.
  - 101 LHU: half at addr[1], zero-extended; addr[0] ignored.
  - 010 LW: full word; addr[1:0] ignored.
  - Other funct3: full word.
  - oor address: ReadDataM = 0.
- Stores happen at the rising edge when MemWriteM = 1:
  - 000 SB: writes byte lane addr[1:0] with WriteDataM[7:0].
  - 001 SH: writes half lane addr[1] with WriteDataM[15:0].
  - 010 SW: writes all four lanes.
  - Other funct3: no write; sets ERR_STATUS[2].
- Misaligned store (SH with addr[0]=1, or SW with addr[1:0]!=0):
  - Write suppressed, memory unchanged.
  - Sets ERR_STATUS[0].
- Store to oor address: ignored; sets ERR_STATUS[1].
- Read-during-write at the same address returns the old data in that cycle and the new data from the next cycle.
- MMIO registers (offset = ALUResultM[11:0]; word access only, funct3 ignored, full 32-bit read/write):
  - 0x000 GPIO_OUT: read/write; drives GpioOut.
  - 0x004 CYCLE:
    - Increments every cycle; wraps 0xFFFF_FFFF -> 0.
    - A store loads WriteDataM; on that edge the written value wins over the increment, and counting resumes from it on the next cycle.
  - 0x008 ERR_STATUS: bits [2:0]; write-1-to-clear. If a new error and a clear of the same bit occur at the same edge, the set wins.
  - 0x00C STORE_COUNT: see Optional Feature.
  - Other offsets: read 0; writes ignored, no error.
- ErrFlag = |ERR_STATUS, registered through the ERR_STATUS register.
- Reset: GpioOut = 0, CYCLE = 0, ERR_STATUS = 0, STORE_COUNT = 0.
  - Any store presented in the reset cycle is dropped.
  - ReadDataM stays combinational during reset.

Optional Feature:
- Macro: DMEM_STORE_COUNT_EN.
- Defined: the 32-bit STORE_COUNT register at MMIO 0x00C.
  - Increments on every committed RAM store (SB/SH/SW that actually writes); wraps to 0.
  - Read-only; stores to it are ignored.
  - Reset value 0.
- Undefined: no counter logic; 0x00C reads 0.

Test Plan:
- SW 0x8765_4321 to 0x10, then LB/LBU/LH/LHU/LW at 0x13 / 0x13 / 0x12 / 0x12 / 0x10 -> 0xFFFF_FF87, 0x0000_0087, 0xFFFF_8765, 0x0000_8765, 0x8765_4321.
- SB 0xAA to 0x21 over word 0x20 = 0x1122_3344 -> word reads 0x1122_AA44; SH 0xBEEF to 0x22 -> 0xBEEF_AA44.
- SW to 0x06 -> memory unchanged, ERR_STATUS = 0x1, ErrFlag = 1; SW 0x1 to 0x1008 -> ERR_STATUS = 0 on the next cycle.
- SW 0xFFFF_FFFE to 0x1004 -> CYCLE reads 0xFFFF_FFFE, 0xFFFF_FFFF, then 0x0 on successive cycles.
- SW 0x5A to 0x1000 -> GpioOut = 0x5A; assert reset for 1 cycle -> GpioOut = 0, CYCLE = 0.
- With DMEM_STORE_COUNT_EN: 3 valid RAM stores + 1 misaligned store -> 0x100C reads 3; without the macro -> reads 0.

Source files
------------

// File: rtl/riscv_dmem_responder_if.sv
// M-stage data-memory port between the RV32I core (master) and its data memory (slave).
interface riscv_dmem_responder_if;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  Func3M;
    logic [31:0] ReadDataM;

    modport master (
        output MemWriteM, ALUResultM, WriteDataM, Func3M,
        input  ReadDataM
    );

    modport slave (
        input  MemWriteM, ALUResultM, WriteDataM, Func3M,
        output ReadDataM
    );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: byte-lane RAM with combinational loads plus a GPIO/CYCLE/ERR_STATUS MMIO window.
// Optional macro DMEM_STORE_COUNT_EN adds a read-only STORE_COUNT register at MMIO offset 0x00C.
module riscv_dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic                         clk,
    input  logic                         reset,
    riscv_dmem_responder_if.slave        bus,
    output logic [31:0]                  GpioOut,
    output logic                         ErrFlag
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   gpioReg;
    logic [31:0]   cycleReg;
    logic [2:0]    errStatus;

    logic          isMmio;
    logic          isRam;
    logic [AW-1:0] wordIdx;
    logic [11:0]   offset;
    logic [31:0]   ramWord;
    logic [7:0]    loadByte;
    logic [15:0]   loadHalf;
    logic [31:0]   ramRead;
    logic [31:0]   mmioRead;

    logic          storeEn;
    logic [3:0]    byteEn;
    logic [31:0]   storeLanes;
    logic          gpioWe;
    logic          cycleWe;
    logic [2:0]    errSet;
    logic [2:0]    errClr;

`ifdef DMEM_STORE_COUNT_EN
    logic [31:0]   storeCount;
`endif

    assign isMmio  = (bus.ALUResultM[31:12] == MMIO_BASE[31:12]);
    assign isRam   = !isMmio && ((bus.ALUResultM >> 2) < 32'(DEPTH_WORDS));
    assign wordIdx = bus.ALUResultM[AW+1:2];
    assign offset  = bus.ALUResultM[11:0];
    assign ramWord = mem[wordIdx];

    always_comb begin
        loadByte = 8'h00;
        case (bus.ALUResultM[1:0])
            2'd0:    loadByte = ramWord[7:0];
            2'd1:    loadByte = ramWord[15:8];
            2'd2:    loadByte = ramWord[23:16];
            default: loadByte = ramWord[31:24];
        endcase
        loadHalf = bus.ALUResultM[1] ? ramWord[31:16] : ramWord[15:0];

        ramRead = ramWord;
        case (bus.Func3M)
            3'b000:  ramRead = {{24{loadByte[7]}}, loadByte};
            3'b100:  ramRead = {24'h0, loadByte};
            3'b001:  ramRead = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  ramRead = {16'h0, loadHalf};
            default: ramRead = ramWord;
        endcase
    end

    always_comb begin
        mmioRead = 32'h0;
        case (offset)
            12'h000: mmioRead = gpioReg;
            12'h004: mmioRead = cycleReg;
            12'h008: mmioRead = {29'h0, errStatus};
`ifdef DMEM_STORE_COUNT_EN
            12'h00C: mmioRead = storeCount;
`endif
            default: mmioRead = 32'h0;
        endcase
    end

    assign bus.ReadDataM = isMmio ? mmioRead : (isRam ? ramRead : 32'h0);

    // Store decode: MMIO writes never raise errors; out-of-range outranks funct3/alignment faults.
    always_comb begin
        storeEn    = bus.MemWriteM && !reset;
        byteEn     = 4'b0000;
        gpioWe     = 1'b0;
        cycleWe    = 1'b0;
        errSet     = 3'b000;
        errClr     = 3'b000;
        storeLanes = bus.WriteDataM;

        case (bus.Func3M)
            3'b000:  storeLanes = {4{bus.WriteDataM[7:0]}};
            3'b001:  storeLanes = {2{bus.WriteDataM[15:0]}};
            default: storeLanes = bus.WriteDataM;
        endcase

        if (storeEn) begin
            if (isMmio) begin
                case (offset)
                    12'h000: gpioWe  = 1'b1;
                    12'h004: cycleWe = 1'b1;
                    12'h008: errClr  = bus.WriteDataM[2:0];
                    default: ;
                endcase
            end else if (isRam) begin
                case (bus.Func3M)
                    3'b000: byteEn = 4'b0001 << bus.ALUResultM[1:0];
                    3'b001: begin
                        if (bus.ALUResultM[0]) errSet[0] = 1'b1;
                        else                   byteEn    = bus.ALUResultM[1] ? 4'b1100 : 4'b0011;
                    end
                    3'b010: begin
                        if (bus.ALUResultM[1:0] != 2'b00) errSet[0] = 1'b1;
                        else                              byteEn    = 4'b1111;
                    end
                    default: errSet[2] = 1'b1;
                endcase
            end else begin
                errSet[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) mem[wordIdx][b*8 +: 8] <= storeLanes[b*8 +: 8];
        end
    end

    // A CYCLE store wins over the increment; an error set wins over a same-edge clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpioReg   <= 32'h0;
            cycleReg  <= 32'h0;
            errStatus <= 3'b000;
        end else begin
            if (gpioWe) gpioReg <= bus.WriteDataM;
            cycleReg  <= cycleWe ? bus.WriteDataM : cycleReg + 32'd1;
            errStatus <= (errStatus & ~errClr) | errSet;
        end
    end

`ifdef DMEM_STORE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)        storeCount <= 32'h0;
        else if (|byteEn) storeCount <= storeCount + 32'd1;
    end
`endif

    assign GpioOut = gpioReg;
    assign ErrFlag = |errStatus;

endmodule
